// File: rtl/rd_hold_ctrl.sv
// rtl/rd_hold_ctrl.sv - round-robin read sequencer holding rd/addr stable for HOLD_CYC cycles
module rd_hold_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  output logic [NUM_CH-1:0]        gnt,
  output logic                     rd,
  output logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     rsp_valid,
  output logic [CH_W-1:0]          rsp_ch,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     busy
);

  localparam int MAXC  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CH_W-1:0]     ptr, ptr_nxt;
  logic [CH_W-1:0]     owner, owner_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [NUM_CH-1:0]   gnt_q, gnt_nxt;
  logic                rsp_valid_q, rsp_valid_nxt;
  logic [CH_W-1:0]     rsp_ch_q, rsp_ch_nxt;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_nxt;

  logic                found;
  logic [CH_W-1:0]     win;
  int                  idx;
  int                  win_i;

  // Search starts at the pointer and wraps, so no channel has fixed priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
    win_i = int'(win);
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    addr_nxt      = addr_q;
    gnt_nxt       = '0;
    rsp_valid_nxt = 1'b0;
    rsp_ch_nxt    = rsp_ch_q;
    rsp_data_nxt  = rsp_data_q;
    case (state)
      S_IDLE: begin
        if (ce && found) begin
          state_nxt = S_READ;
          gnt_nxt   = NUM_CH'(1) << win;
          addr_nxt  = req_addr[win_i*ADDR_W +: ADDR_W];
          owner_nxt = win;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
          ptr_nxt   = (win_i == NUM_CH - 1) ? '0 : win + 1'b1;
        end
      end
      S_READ: begin
        if (cnt == '0) begin
          rsp_valid_nxt = 1'b1;
          rsp_ch_nxt    = owner;
          rsp_data_nxt  = mem_rdata;
          if (GAP_CYC > 0) begin
            state_nxt = S_GAP;
            cnt_nxt   = CNT_W'(GAP_CYC - 1);
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      owner       <= '0;
      addr_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ptr         <= ptr_nxt;
      owner       <= owner_nxt;
      addr_q      <= addr_nxt;
      gnt_q       <= gnt_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_ch_q    <= rsp_ch_nxt;
      rsp_data_q  <= rsp_data_nxt;
    end
  end

  assign rd        = (state == S_READ);
  assign busy      = (state != S_IDLE);
  assign addr      = addr_q;
  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ch    = rsp_ch_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rd_hold_ctrl.sv
// tb/tb_rd_hold_ctrl.sv - directed bench for rd_hold_ctrl (HOLD 2/GAP 0 and HOLD 4/GAP 2)
module tb_rd_hold_ctrl;

  logic        clk, rst, ce;
  logic [1:0]  req;
  logic [15:0] req_addr;

  logic [1:0]  gnt_a, gnt_b;
  logic        rd_a, rd_b, rsp_valid_a, rsp_valid_b, rsp_ch_a, rsp_ch_b, busy_a, busy_b;
  logic [7:0]  addr_a, addr_b, mem_a, mem_b, rsp_data_a, rsp_data_b;

  int checks = 0;
  int errors = 0;

  // Memory model: data is the address XOR 8'h99 (8'h3C reads back as 8'hA5).
  assign mem_a = addr_a ^ 8'h99;
  assign mem_b = addr_b ^ 8'h99;

  rd_hold_ctrl #(.ADDR_W(8), .DATA_W(8), .NUM_CH(2), .HOLD_CYC(2), .GAP_CYC(0)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .req(req), .req_addr(req_addr), .gnt(gnt_a), .rd(rd_a),
    .addr(addr_a), .mem_rdata(mem_a), .rsp_valid(rsp_valid_a), .rsp_ch(rsp_ch_a),
    .rsp_data(rsp_data_a), .busy(busy_a));

  rd_hold_ctrl #(.ADDR_W(8), .DATA_W(8), .NUM_CH(2), .HOLD_CYC(4), .GAP_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .req(req), .req_addr(req_addr), .gnt(gnt_b), .rd(rd_b),
    .addr(addr_b), .mem_rdata(mem_b), .rsp_valid(rsp_valid_b), .rsp_ch(rsp_ch_b),
    .rsp_data(rsp_data_b), .busy(busy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; ce = 1'b0; req = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; req = 2'b00; req_addr = 16'h0000;
    tick(); tick();
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_rd got %0h exp 0", rd_a); end
    checks++; if (addr_a !== 8'h00) begin errors++; $display("FAIL reset_addr got %0h exp 00", addr_a); end
    checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL reset_gnt got %0h exp 0", gnt_a); end
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid_a); end
    checks++; if (rsp_data_a !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %0h exp 00", rsp_data_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy_a); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    ce = 1'b1; req = 2'b01; req_addr = 16'h003C;
    tick();
    checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL single_gnt got %0h exp 1", gnt_a); end
    checks++; if (rd_a !== 1'b1) begin errors++; $display("FAIL single_rd0 got %0h exp 1", rd_a); end
    checks++; if (addr_a !== 8'h3C) begin errors++; $display("FAIL single_addr got %0h exp 3c", addr_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy got %0h exp 1", busy_a); end
    req = 2'b00;
    tick();
    checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL single_gnt_pulse got %0h exp 0", gnt_a); end
    checks++; if (rd_a !== 1'b1) begin errors++; $display("FAIL single_rd1 got %0h exp 1", rd_a); end
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %0h exp 0", rsp_valid_a); end
    tick();
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL single_rd_fall got %0h exp 0", rd_a); end
    checks++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0h exp 1", rsp_valid_a); end
    checks++; if (rsp_ch_a !== 1'b0) begin errors++; $display("FAIL single_rsp_ch got %0h exp 0", rsp_ch_a); end
    checks++; if (rsp_data_a !== 8'hA5) begin errors++; $display("FAIL single_rsp_data got %0h exp a5", rsp_data_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %0h exp 0", busy_a); end
    tick();
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL single_rsp_pulse got %0h exp 0", rsp_valid_a); end
    checks++; if (addr_a !== 8'h3C) begin errors++; $display("FAIL single_addr_keep got %0h exp 3c", addr_a); end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    logic [7:0] ea;
    apply_reset();
    ce = 1'b1; req = 2'b11; req_addr = 16'h2010;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 1) ? 2'b10 : 2'b01;
      ea = (k % 2 == 1) ? 8'h20 : 8'h10;
      tick();
      checks++; if (gnt_a !== eg) begin errors++; $display("FAIL rr_gnt%0d got %0h exp %0h", k, gnt_a, eg); end
      checks++; if (rd_a !== 1'b1) begin errors++; $display("FAIL rr_rd%0d got %0h exp 1", k, rd_a); end
      checks++; if (addr_a !== ea) begin errors++; $display("FAIL rr_addr%0d got %0h exp %0h", k, addr_a, ea); end
      tick(); tick();
      checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL rr_rd_low%0d got %0h exp 0", k, rd_a); end
      checks++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid%0d got %0h exp 1", k, rsp_valid_a); end
      checks++; if (rsp_ch_a !== eg[1]) begin errors++; $display("FAIL rr_rsp_ch%0d got %0h exp %0h", k, rsp_ch_a, eg[1]); end
      checks++; if (rsp_data_a !== (ea ^ 8'h99)) begin errors++; $display("FAIL rr_rsp_data%0d got %0h exp %0h", k, rsp_data_a, ea ^ 8'h99); end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_hold_gap();
    logic [7:0] ea;
    apply_reset();
    ce = 1'b1; req = 2'b01; req_addr = 16'h0044;
    for (int r = 0; r < 2; r++) begin
      ea = (r == 1) ? 8'h55 : 8'h44;
      tick();
      checks++; if (gnt_b !== 2'b01) begin errors++; $display("FAIL hg_gnt%0d got %0h exp 1", r, gnt_b); end
      checks++; if (rd_b !== 1'b1) begin errors++; $display("FAIL hg_rd_rise%0d got %0h exp 1", r, rd_b); end
      checks++; if (addr_b !== ea) begin errors++; $display("FAIL hg_addr%0d got %0h exp %0h", r, addr_b, ea); end
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++; if (rd_b !== 1'b1) begin errors++; $display("FAIL hg_rd_hold%0d_%0d got %0h exp 1", r, i, rd_b); end
        checks++; if (addr_b !== ea) begin errors++; $display("FAIL hg_addr_hold%0d_%0d got %0h exp %0h", r, i, addr_b, ea); end
      end
      tick();
      checks++; if (rd_b !== 1'b0) begin errors++; $display("FAIL hg_rd_fall%0d got %0h exp 0", r, rd_b); end
      checks++; if (rsp_valid_b !== 1'b1) begin errors++; $display("FAIL hg_rsp_valid%0d got %0h exp 1", r, rsp_valid_b); end
      checks++; if (rsp_data_b !== (ea ^ 8'h99)) begin errors++; $display("FAIL hg_rsp_data%0d got %0h exp %0h", r, rsp_data_b, ea ^ 8'h99); end
      req_addr = 16'h0055;
      for (int i = 0; i < 2; i++) begin
        tick();
        checks++; if (rd_b !== 1'b0) begin errors++; $display("FAIL hg_gap_rd%0d_%0d got %0h exp 0", r, i, rd_b); end
        checks++; if (gnt_b !== 2'b00) begin errors++; $display("FAIL hg_gap_gnt%0d_%0d got %0h exp 0", r, i, gnt_b); end
        checks++; if (addr_b !== ea) begin errors++; $display("FAIL hg_gap_addr%0d_%0d got %0h exp %0h", r, i, addr_b, ea); end
        checks++; if (busy_b !== (i == 0)) begin errors++; $display("FAIL hg_gap_busy%0d_%0d got %0h exp %0h", r, i, busy_b, (i == 0)); end
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_ce_drop();
    apply_reset();
    ce = 1'b1; req = 2'b01; req_addr = 16'h0030;
    tick();
    checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL ce_gnt got %0h exp 1", gnt_a); end
    ce = 1'b0;
    tick();
    checks++; if (rd_a !== 1'b1) begin errors++; $display("FAIL ce_rd_hold got %0h exp 1", rd_a); end
    tick();
    checks++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL ce_rsp_valid got %0h exp 1", rsp_valid_a); end
    checks++; if (rsp_data_a !== 8'hA9) begin errors++; $display("FAIL ce_rsp_data got %0h exp a9", rsp_data_a); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL ce_no_gnt%0d got %0h exp 0", i, gnt_a); end
      checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL ce_no_rd%0d got %0h exp 0", i, rd_a); end
    end
    ce = 1'b1;
    tick();
    checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL ce_regrant got %0h exp 1", gnt_a); end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_input_change();
    apply_reset();
    ce = 1'b1; req = 2'b10; req_addr = 16'h5A00;
    tick();
    checks++; if (gnt_a !== 2'b10) begin errors++; $display("FAIL chg_gnt got %0h exp 2", gnt_a); end
    checks++; if (addr_a !== 8'h5A) begin errors++; $display("FAIL chg_addr0 got %0h exp 5a", addr_a); end
    req_addr = 16'h7711; req = 2'b01;
    tick();
    checks++; if (addr_a !== 8'h5A) begin errors++; $display("FAIL chg_addr1 got %0h exp 5a", addr_a); end
    checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL chg_no_gnt got %0h exp 0", gnt_a); end
    req = 2'b00;
    tick();
    checks++; if (rsp_data_a !== 8'hC3) begin errors++; $display("FAIL chg_rsp_data got %0h exp c3", rsp_data_a); end
    checks++; if (rsp_ch_a !== 1'b1) begin errors++; $display("FAIL chg_rsp_ch got %0h exp 1", rsp_ch_a); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    ce = 1'b1; req = 2'b11; req_addr = 16'h2211;
    tick(); tick(); tick();
    tick();
    checks++; if (gnt_a !== 2'b10) begin errors++; $display("FAIL mid_pre_gnt got %0h exp 2", gnt_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL mid_rd got %0h exp 0", rd_a); end
    checks++; if (addr_a !== 8'h00) begin errors++; $display("FAIL mid_addr got %0h exp 00", addr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy got %0h exp 0", busy_a); end
    checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL mid_gnt got %0h exp 0", gnt_a); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL mid_no_rsp%0d got %0h exp 0", i, rsp_valid_a); end
    end
    rst = 1'b0;
    tick();
    checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL mid_ptr_gnt got %0h exp 1", gnt_a); end
    checks++; if (addr_a !== 8'h11) begin errors++; $display("FAIL mid_ptr_addr got %0h exp 11", addr_a); end
    req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold_gap();
    test_ce_drop();
    test_input_change();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_hold_ctrl.md
# rd_hold_ctrl

Parametrised memory read sequencer that arbitrates read requests from `NUM_CH` requesters and drives a single-port memory read interface. It guarantees `rd` is held for exactly `HOLD_CYC` cycles with `addr` stable, and returns the captured data tagged with the requesting channel. It sits between bus-side requesters and the memory macro. It generalises the fixed two-cycle `rd`/`addr` stability rule into a configurable, multi-channel controller.

## Interface
- `ADDR_W`, 8, address width
- `DATA_W`, 8, data width
- `NUM_CH`, 2, number of requesters (1..8)
- `HOLD_CYC`, 2, cycles `rd` stays high per read (≥1)
- `GAP_CYC`, 0, extra idle cycles forced after each read (≥0)
- `CH_W`, derived, equal to max(1, clog2(NUM_CH))

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  reset; asynchronous, active-high
- `ce`  in  1  chip enable; new grants only while high
- `req`  in  NUM_CH  per-channel read request (level, held until granted)
- `req_addr`  in  NUM_CH*ADDR_W  per-channel address; channel k is at bits [k*ADDR_W +: ADDR_W]
- `gnt`  out  NUM_CH  one-hot, one-cycle grant pulse
- `rd`  out  1  memory read strobe
- `addr`  out  ADDR_W  memory address
- `mem_rdata`  in  DATA_W  memory read data
- `rsp_valid`  out  1  one-cycle response strobe
- `rsp_ch`  out  CH_W  channel that owns the response
- `rsp_data`  out  DATA_W  captured read data
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, READ, GAP.
- **IDLE → READ:** at an edge where `ce`=1 and any `req` bit is set:
  - grant the round-robin winner;
  - capture its `req_addr` into `addr`;
  - set `rd`=1 and load the hold counter with `HOLD_CYC`-1.
- **READ:**
  - `rd`=1 and `addr` unchanged.
  - On the edge where the counter is 0:
    - capture `mem_rdata` into `rsp_data`, set `rsp_valid`=1, set `rsp_ch` to the owning channel, and drop `rd` to 0;
    - go to GAP if `GAP_CYC`>0, else go to IDLE.
- **GAP:** stay for `GAP_CYC` cycles with `rd`=0, then go to IDLE.
- **Round robin:**
  - The pointer resets to 0.
  - The winner is the first requesting channel at index ≥ pointer, wrapping around.
  - After a grant, the pointer becomes winner+1 mod `NUM_CH`.
- **`addr` between reads:** `addr` keeps its last value after a read and changes only on a grant edge.
- **`ce` deasserted mid-read:** the read in progress completes unchanged, with full `HOLD_CYC` and the response. No new grant is issued while `ce`=0.
- **Request changes during READ/GAP:** `req`/`req_addr` changes have no effect. Requests are only sampled in IDLE.
- **Simultaneous requests:** resolved by round robin only. There is no fixed priority.

## Timing
- **Reset values** (applied immediately on `rst` rising, asynchronously):
  - `rd`=0, `addr`=0, `gnt`=0;
  - `rsp_valid`=0, `rsp_ch`=0, `rsp_data`=0;
  - `busy`=0;
  - state IDLE, pointer 0.
- **Reset mid-read:** `rd` falls without completing. No response is produced for the aborted read.
- **Grant at edge N** (request sampled in IDLE):
  - `gnt`[k] is high for cycle N..N+1 only.
  - `rd`=1 and the new `addr` are valid from edge N through edge N+`HOLD_CYC`.
- **Response:** `mem_rdata` is sampled at edge N+`HOLD_CYC`. `rsp_valid` is high for exactly the one cycle after that edge.
- **Back-to-back reads:**
  - The earliest next grant is at edge N+`HOLD_CYC`+`GAP_CYC`+1.
  - `rd` is therefore low for at least `GAP_CYC`+1 cycles between reads.
  - Every read produces a distinct `rd` rising edge.
- **Invariant while `rd`=1:** `addr` is stable and `rd` is stable for `HOLD_CYC` consecutive cycles. This holds regardless of `ce`.
- **`busy` timing:** `busy` rises with `rd` and falls on the edge returning to IDLE.

## Test plan
- **Reset then single read** (`NUM_CH`=2, `HOLD_CYC`=2): release `rst`, set `ce`=1, `req`=01, `addr0`=8'h3C, memory returns 8'hA5.
  - Expect `gnt`=01 for 1 cycle.
  - Expect `rd` high for exactly 2 cycles with `addr`=8'h3C.
  - Expect `rsp_valid` for 1 cycle with `rsp_ch`=0 and `rsp_data`=8'hA5.
- **Round robin:** hold `req`=11 with `ce`=1 for 4 reads.
  - Expect grant order 0,1,0,1.
  - Expect each `rsp_ch` to match its grant, and `rd` low ≥1 cycle between reads.
- **`HOLD_CYC`=4, `GAP_CYC`=2:** run back-to-back reads.
  - Expect `rd` high 4 cycles, then low exactly 3 cycles, then the next rise.
  - Expect `addr` to change only at grant edges.
- **`ce` drop mid-read:** deassert `ce` one cycle after a grant while `req` stays high.
  - Expect the current read to complete with full hold and a response.
  - Expect no further `gnt` until `ce`=1 again.
- **Input changes during READ:** change `req_addr` of the granted channel during READ.
  - Expect `addr` unchanged and `rsp_data` taken from the original address.
- **Async reset mid-read:** assert `rst` between clock edges during READ.
  - Expect `rd`=0, `addr`=0, `busy`=0 immediately.
  - Expect no `rsp_valid`, and the pointer back at 0 (channel 0 granted first afterwards with `req`=11).
